regfile_wb: RTL
===============

# regfile_wb

Architectural register file for the pipelined CPU: 32 × 64-bit registers, two combinational read ports for the decode stage, and one clocked write port driven by write-back. It sits directly downstream of the write-select decoder; the one-hot decoded enable, gated by RegWrite, selects which register captures WriteData. X31 is hardwired zero (XZR).

## Interface
- NUM_REGS, 32, register count; power of two.
- DATA_W, 64, register width in bits.
- ZERO_REG, 31, index of the hardwired-zero register.
- ADDR_W, $clog2(NUM_REGS), register index width; derived, not overridden.

- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears every register.
- RegWrite  input  1  write enable from write-back.
- WriteRegister  input  ADDR_W  destination register index.
- WriteData  input  DATA_W  value to write.
- ReadRegister1  input  ADDR_W  read port 1 index.
- ReadRegister2  input  ADDR_W  read port 2 index.
- ReadData1  output  DATA_W  contents of ReadRegister1, combinational.
- ReadData2  output  DATA_W  contents of ReadRegister2, combinational.

## Operation
- Write decode: WriteRegister goes to a 5→32 one-hot decoder with RegWrite as its enable. Exactly one enable is high when RegWrite=1; none are high otherwise.
- Register i captures WriteData on the rising clk edge when its enable is high. Otherwise it holds its value.
- ZERO_REG has no storage element. Writes to it are discarded, and reads of it always return 0.
- Read ports are pure muxes over the register array, indexed by ReadRegister1/2. Both ports may select the same register.
- reset_n low:
  - Asynchronously forces all registers to 0 immediately, without waiting for a clock edge.
  - While low, ReadData1/2 return 0 for every index.
  - Writes presented during reset are ignored.
- Reset deasserted mid-operation: the first write takes effect on the first rising edge with reset_n high and RegWrite=1.
- No X propagation: an index that is X or out of range is a bench error, not a design case, since all 5-bit indices are valid.

## Timing
- Write latency: 1 cycle. Data presented in cycle N is visible on read ports after edge N (in cycle N+1).
- Read latency: 0 cycles, combinational from ReadRegister and the array.
- Same-cycle read and write to the same register, with bypass disabled: the read returns the old value until the edge.
- Reset values: every register is 0, so ReadData1 = ReadData2 = 0.
- Simultaneous reset_n falling and write edge: reset wins and the register stays 0.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If RegWrite=1, reset_n=1, WriteRegister==ReadRegisterK and WriteRegister≠ZERO_REG, then ReadDataK = WriteData in the same cycle. This removes the WB→ID hazard, so the forwarding unit need not cover it.
- Undefined: no forwarding. Reads always reflect the stored array; the hazard unit must stall or forward one cycle.

## Structure
- Shared package cpu_pkg:
  - REG_ADDR_W=5, DATA_W=64, ZERO_REG=31.
  - typedef reg_idx_t (logic [4:0]), typedef word_t (logic [63:0]).
- Sub-module decoder5_32:
  - Input: 5-bit index plus enable; output: 32-bit one-hot.
  - Built as a 2→4 stage whose outputs enable four 3→8 stages.
- Top level holds:
  - the register array, as a generate loop of DATA_W-wide enabled flops with async active-low clear;
  - the two read muxes;
  - the optional bypass compare.

## Test plan
- Reset: pulse reset_n low mid-cycle after loading X5=0xDEAD → ReadData1 with ReadRegister1=5 reads 0 immediately, before any clk edge.
- Write/read all: write X0..X30 with value 0x1000+i on consecutive cycles, then read every pair (i, 30−i) → 0x1000+i and 0x1000+30−i.
- Zero register: write X31=0xFFFF_FFFF_FFFF_FFFF → both ports at index 31 read 0.
- RegWrite low: WriteRegister=7, WriteData=0x55, RegWrite=0 for 3 edges → X7 is unchanged at its prior value 0x1007.
- Same-cycle hazard: X9=0x1009; write X9=0xABCD while reading X9 on both ports → 0xABCD in the same cycle with REGFILE_BYPASS_EN, 0x1009 without; 0xABCD after the edge in both builds.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, zero-register index and register/word types
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam int ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - write-back / decode-stage bus into the register file
//
// Signals (master = pipeline, slave = register file):
//   RegWrite       master->slave  write enable from write-back
//   WriteRegister  master->slave  destination register index
//   WriteData      master->slave  value to write
//   ReadRegister1  master->slave  read port 1 index
//   ReadRegister2  master->slave  read port 2 index
//   ReadData1      slave->master  contents of ReadRegister1 (combinational)
//   ReadData2      slave->master  contents of ReadRegister2 (combinational)
interface regfile_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_wb_decoder5_32.sv
// rtl/regfile_wb_decoder5_32.sv - 5-to-32 one-hot write-select decoder with enable
//
// Ports:
//   idx     input  5   register index to decode
//   en      input  1   decoder enable (RegWrite); all outputs low when 0
//   onehot  output 32  one-hot select, bit idx set when en=1
module decoder5_32
    import cpu_pkg::*;
(
    input  reg_idx_t    idx,
    input  logic        en,
    output logic [31:0] onehot
);

    // First stage: idx[4:3] picks one of four groups of eight.
    logic [3:0] grp_en;

    always_comb begin
        grp_en = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            grp_en[g] = en && (idx[4:3] == 2'(g));
        end
    end

    // Second stage: each enabled group decodes idx[2:0] to one of its eight lines.
    always_comb begin
        onehot = '0;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 8; k++) begin
                onehot[g*8 + k] = grp_en[g] && (idx[2:0] == 3'(k));
            end
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 32 x 64-bit architectural register file, X31 hardwired zero
//
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-through forwarding).
//
// Ports:
//   clk      input  1  rising-edge clock
//   reset_n  input  1  asynchronous active-low clear of every register
//   rf       slave  regfile_wb_if: RegWrite/WriteRegister/WriteData write port,
//                   ReadRegister1/2 -> ReadData1/2 combinational read ports
module regfile_wb #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic          clk,
    input  logic          reset_n,
    regfile_wb_if.slave   rf
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [31:0]       wr_en;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // The decoder is the fixed 5->32 write-select block sitting upstream.
    decoder5_32 u_decoder (
        .idx    (rf.WriteRegister),
        .en     (rf.RegWrite),
        .onehot (wr_en)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            // No storage: the decoded enable for this index is intentionally dropped.
            logic unused_zero_en;
            assign unused_zero_en = wr_en[i];
            assign regs_q[i]      = '0;
        end else begin : g_word
            logic [DATA_W-1:0] word_d;
            logic [DATA_W-1:0] word_q;

            always_comb begin
                word_d = wr_en[i] ? rf.WriteData : word_q;
            end

            // Async clear means a reset edge coinciding with a write edge leaves 0.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign regs_q[i] = word_q;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward WriteData onto a read port in the same cycle it is being written.
    logic fwd_ok;
    logic fwd1;
    logic fwd2;

    always_comb begin
        fwd_ok = rf.RegWrite && reset_n && (rf.WriteRegister != ADDR_W'(ZERO_REG));
        fwd1   = fwd_ok && (rf.WriteRegister == rf.ReadRegister1);
        fwd2   = fwd_ok && (rf.WriteRegister == rf.ReadRegister2);
    end

    always_comb begin
        rf.ReadData1 = fwd1 ? rf.WriteData : regs_q[rf.ReadRegister1];
        rf.ReadData2 = fwd2 ? rf.WriteData : regs_q[rf.ReadRegister2];
    end
`else
    always_comb begin
        rf.ReadData1 = regs_q[rf.ReadRegister1];
        rf.ReadData2 = regs_q[rf.ReadRegister2];
    end
`endif

endmodule
